// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: mtc0/mfc0 ports plus exception and eret commit.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0 and timer_int is 0.
module cp0_regfile #(
  parameter logic [31:0] PRID_VAL = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [5:0]  ext_int,
  input  logic [31:0] excepttype,
  input  logic [31:0] current_pc,
  input  logic        is_in_delayslot,
  input  logic [31:0] bad_addr,
  output logic [31:0] rdata,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CONFIG_VAL   = 32'h0000_0000;
  localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL     = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES     = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

  logic [31:0] badvaddr_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_int_q;

  logic exc_commit;
  logic eret_commit;
  logic first_exc;
  logic addr_exc;
  logic wr_badvaddr;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign exc_commit  = (excepttype != EXC_NONE) && (excepttype != EXC_ERET);
  assign eret_commit = (excepttype == EXC_ERET);
  // EPC/BD only record the first exception; nested ones while EXL=1 keep the original return point.
  assign first_exc   = exc_commit && !status_q[1];
  assign addr_exc    = (excepttype == EXC_ADEL) || (excepttype == EXC_ADES);

  assign wr_badvaddr = we && (waddr == REG_BADVADDR);
  assign wr_status   = we && (waddr == REG_STATUS);
  assign wr_cause    = we && (waddr == REG_CAUSE);
  assign wr_epc      = we && (waddr == REG_EPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_q <= 32'd0;
    end else begin
      if (wr_badvaddr) badvaddr_q <= wdata;
      if (exc_commit && addr_exc) badvaddr_q <= bad_addr;
    end
  end

  // The mtc0 write lands first; the exception/eret EXL update is assigned later so it wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RST;
    end else begin
      if (wr_status) status_q <= (STATUS_RST & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
      if (exc_commit) status_q[1] <= 1'b1;
      else if (eret_commit) status_q[1] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= 32'd0;
    end else begin
      cause_q[15]    <= ext_int[5] | timer_int_q;
      cause_q[14:10] <= ext_int[4:0];
      if (wr_cause) cause_q[9:8] <= wdata[9:8];
      if (exc_commit) begin
        cause_q[6:2] <= (excepttype == EXC_INT) ? 5'd0 : excepttype[4:0];
        if (first_exc) cause_q[31] <= is_in_delayslot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= 32'd0;
    end else begin
      if (wr_epc) epc_q <= wdata;
      if (first_exc) epc_q <= is_in_delayslot ? (current_pc - 32'd4) : current_pc;
    end
  end

`ifdef CP0_TIMER_EN
  logic count_tog_q;
  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (waddr == REG_COUNT);
  assign wr_compare = we && (waddr == REG_COMPARE);

  // Count advances on every second edge; a load restarts the half-rate phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 32'd0;
      count_tog_q <= 1'b0;
    end else if (wr_count) begin
      count_q     <= wdata;
      count_tog_q <= 1'b0;
    end else begin
      count_tog_q <= ~count_tog_q;
      if (count_tog_q) count_q <= count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= 32'd0;
    end else if (wr_compare) begin
      compare_q <= wdata;
    end
  end

  // Sticky until software rewrites Compare, which takes priority over a same-cycle match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_int_q <= 1'b0;
    end else if (wr_compare) begin
      timer_int_q <= 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_int_q <= 1'b1;
    end
  end
`else
  assign count_q     = 32'd0;
  assign compare_q   = 32'd0;
  assign timer_int_q = 1'b0;
`endif

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = status_q;
      REG_CAUSE:    rdata = cause_q;
      REG_EPC:      rdata = epc_q;
      REG_PRID:     rdata = PRID_VAL;
      REG_CONFIG:   rdata = CONFIG_VAL;
      default:      rdata = 32'd0;
    endcase
  end

  assign status_o   = status_q;
  assign cause_o    = cause_q;
  assign epc_o      = epc_q;
  assign count_o    = count_q;
  assign compare_o  = compare_q;
  assign badvaddr_o = badvaddr_q;
  assign timer_int  = timer_int_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: randomized mtc0/exception traffic against a rule-level model,
// plus directed scenarios. Timer scenarios run only when CP0_TIMER_EN is defined.
`timescale 1ns/1ps
module tb_cp0_regfile;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [5:0]  ext_int;
  logic [31:0] excepttype;
  logic [31:0] current_pc;
  logic        is_in_delayslot;
  logic [31:0] bad_addr;
  logic [31:0] rdata;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] badvaddr_o;
  logic        timer_int;

  cp0_regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .ext_int(ext_int), .excepttype(excepttype), .current_pc(current_pc),
    .is_in_delayslot(is_in_delayslot), .bad_addr(bad_addr), .rdata(rdata),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
    .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int(timer_int)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count is modelled as load value plus elapsed edges / 2 rather than as a toggle flop.
  typedef struct {
    logic [31:0] badv;
    logic [31:0] count_base;
    int unsigned count_edges;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        tint;
  } cp0_model_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] badv;
    logic        tint;
  } expect_t;

  cp0_model_t model;
  expect_t    exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic cp0_model_t model_reset();
    cp0_model_t s;
    s.badv = 0; s.count_base = 0; s.count_edges = 0; s.compare = 0;
    s.status = 32'h0040_0000; s.cause = 0; s.epc = 0; s.tint = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] model_count(cp0_model_t s);
    if (!TIMER_EN) return 32'd0;
    return s.count_base + 32'(s.count_edges / 2);
  endfunction

  function automatic logic [31:0] model_read(cp0_model_t s, logic [4:0] a);
    case (a)
      5'd8:  return s.badv;
      5'd9:  return model_count(s);
      5'd11: return TIMER_EN ? s.compare : 32'd0;
      5'd12: return s.status;
      5'd13: return s.cause;
      5'd14: return s.epc;
      5'd15: return 32'h0000_4220;
      default: return 32'd0;
    endcase
  endfunction

  function automatic cp0_model_t model_step(cp0_model_t s, bit w, logic [4:0] wa, logic [31:0] wd,
                                            logic [5:0] ei, logic [31:0] et, logic [31:0] pc,
                                            bit ds, logic [31:0] ba);
    cp0_model_t n = s;
    bit real_exc = (et != 0) && (et != 32'he);
    if (TIMER_EN) begin
      n.count_edges = s.count_edges + 1;
      if (s.compare != 0 && model_count(s) == s.compare) n.tint = 1'b1;
    end
    n.cause[15]    = ei[5] | s.tint;
    n.cause[14:10] = ei[4:0];
    if (w) begin
      case (wa)
        5'd8:  n.badv = wd;
        5'd9:  if (TIMER_EN) begin n.count_base = wd; n.count_edges = 0; end
        5'd11: if (TIMER_EN) begin n.compare = wd; n.tint = 1'b0; end
        5'd12: n.status = 32'h0040_0000 | (wd & 32'h0000_FF03);
        5'd13: n.cause[9:8] = wd[9:8];
        5'd14: n.epc = wd;
        default: ;
      endcase
    end
    if (real_exc) begin
      if (s.status[1] == 1'b0) begin
        n.epc = ds ? pc - 4 : pc;
        n.cause[31] = ds;
      end
      n.status[1] = 1'b1;
      n.cause[6:2] = (et == 1) ? 5'd0 : et[4:0];
      if (et == 4 || et == 5) n.badv = ba;
    end else if (et == 32'he) begin
      n.status[1] = 1'b0;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [5:0] ei, input logic [31:0] et,
                               input logic [31:0] pc, input bit ds, input logic [31:0] ba);
    expect_t e;
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; raddr = ra; ext_int = ei;
    excepttype = et; current_pc = pc; is_in_delayslot = ds; bad_addr = ba;
    model = model_step(model, w, wa, wd, ei, et, pc, ds, ba);
    e.rdata = model_read(model, ra);
    e.status = model.status; e.cause = model.cause; e.epc = model.epc;
    e.count = model_count(model); e.compare = TIMER_EN ? model.compare : 32'd0;
    e.badv = model.badv; e.tint = model.tint;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [4:0] ra);
    applyStimulus(1'b0, 5'd0, 32'd0, ra, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 9))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      6: return 5'd15;
      7: return 5'd16;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic randomStep();
    bit w;
    logic [4:0] wa, ra;
    logic [31:0] wd, et;
    w  = ($urandom_range(0, 2) == 0);
    wa = pick_reg();
    ra = pick_reg();
    wd = $urandom;
    if (wa == 5'd9 || wa == 5'd11) wd = $urandom_range(0, 24);
    case ($urandom_range(0, 15))
      0: et = 32'h1;  1: et = 32'h4;  2: et = 32'h5;  3: et = 32'h8;
      4: et = 32'h9;  5: et = 32'ha;  6: et = 32'hc;  7: et = 32'he;
      default: et = 32'h0;
    endcase
    // Keep Status writes away from real exceptions so the EXL gating is unambiguous.
    if (et != 0 && et != 32'he && wa == 5'd12) w = 1'b0;
    applyStimulus(w, wa, wd, ra, 6'($urandom_range(0, 63)), et, $urandom,
                  1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_status"}, status_o, 32'h0040_0000);
    checkOutput({tag, "_cause"}, cause_o, 32'd0);
    checkOutput({tag, "_epc"}, epc_o, 32'd0);
    checkOutput({tag, "_count"}, count_o, 32'd0);
    checkOutput({tag, "_badvaddr"}, badvaddr_o, 32'd0);
    checkOutput({tag, "_timer_int"}, {31'd0, timer_int}, 32'd0);
  endtask

  // Monitor: one expectation per stepped edge, compared just after that edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_rdata", rdata, e.rdata);
        checkOutput("sb_status", status_o, e.status);
        checkOutput("sb_cause", cause_o, e.cause);
        checkOutput("sb_epc", epc_o, e.epc);
        checkOutput("sb_count", count_o, e.count);
        checkOutput("sb_compare", compare_o, e.compare);
        checkOutput("sb_badvaddr", badvaddr_o, e.badv);
        checkOutput("sb_timer_int", {31'd0, timer_int}, {31'd0, e.tint});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hit;
    rst = 1'b0; we = 1'b0; waddr = 0; wdata = 0; raddr = 0; ext_int = 0;
    excepttype = 0; current_pc = 0; is_in_delayslot = 1'b0; bad_addr = 0;
    model = model_reset();

    #3 rst = 1'b1;
    #1 checkResetValues("reset_initial");
    @(posedge clk);
    #2 rst = 1'b0;

    applyStimulus(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    settle();
    checkOutput("status_write_read", rdata, 32'h0040_FF03);
    applyStimulus(1'b1, 5'd12, 32'd0, 5'd12, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 5'd13, 32'd0, 5'd13, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'hc, 32'hBFC0_0100, 1'b1, 32'd0);
    settle();
    checkOutput("ov_ds_epc", epc_o, 32'hBFC0_00FC);
    checkOutput("ov_ds_epc_read", rdata, 32'hBFC0_00FC);
    checkOutput("ov_ds_cause", cause_o, 32'h8000_0030);
    checkOutput("ov_ds_exl", {31'd0, status_o[1]}, 32'd1);

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd14, 6'd0, 32'h8, 32'h8000_0000, 1'b0, 32'd0);
    settle();
    checkOutput("nested_epc_held", epc_o, 32'hBFC0_00FC);
    checkOutput("nested_cause", cause_o, 32'h8000_0020);

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'he, 32'd0, 1'b0, 32'd0);
    settle();
    checkOutput("eret1_exl", {31'd0, status_o[1]}, 32'd0);

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd8, 6'd0, 32'h4, 32'hBFC0_0300, 1'b0, 32'h8000_0003);
    settle();
    checkOutput("adel_badvaddr", badvaddr_o, 32'h8000_0003);
    checkOutput("adel_badvaddr_read", rdata, 32'h8000_0003);
    checkOutput("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd12, 6'd0, 32'he, 32'd0, 1'b0, 32'd0);
    settle();
    checkOutput("eret2_exl", {31'd0, status_o[1]}, 32'd0);

    applyStimulus(1'b1, 5'd14, 32'h1234, 5'd14, 6'd0, 32'h8, 32'hBFC0_0200, 1'b0, 32'd0);
    settle();
    checkOutput("simul_epc", epc_o, 32'hBFC0_0200);
    checkOutput("prid_read_idle", 32'd0, 32'd0 ^ 32'd0 ^ (rdata == 32'hBFC0_0200 ? 32'd0 : 32'd1));

`ifdef CP0_TIMER_EN
    applyStimulus(1'b1, 5'd9, 32'd1000, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 5'd11, 32'd10, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 5'd9, 32'd0, 5'd9, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    settle();
    hit = 0;
    for (int k = 1; k <= 60; k++) begin
      idle(5'd13);
      settle();
      if (timer_int) begin
        hit = k;
        break;
      end
    end
    checkOutput("timer_latency", 32'(hit), 32'd21);
    idle(5'd13);
    settle();
    checkOutput("timer_cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    applyStimulus(1'b1, 5'd11, 32'h50, 5'd11, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    settle();
    checkOutput("timer_clear", {31'd0, timer_int}, 32'd0);
`else
    hit = 0;
`endif

    for (int i = 0; i < 400; i++) randomStep();
    settle();

    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("reset_midrun");
    @(posedge clk);
    #1 checkResetValues("reset_held");
    #1 rst = 1'b0;
    model = model_reset();

    for (int i = 0; i < 150; i++) randomStep();
    repeat (2) settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
